// File: rtl/bsg_link_pkg.sv
// Shared link constants: channel width, beats per word, credit limit and the beat-to-byte-lane map.
// Used by both ends of the byte-serial link so the lane ordering cannot drift apart.
package bsg_link_pkg;

  localparam int BSG_LINK_CH_WIDTH = 8;
  localparam int BSG_LINK_STEPS    = 4;
  localparam int BSG_LINK_CREDITS  = 64;

  typedef logic [1:0] bsg_link_step_t;

  localparam bsg_link_step_t BSG_LINK_LAST_STEP = 2'd3;

  // Byte lane of the 64-bit word carried by each channel, packed 3 bits per step (step 0 in the LSBs).
  localparam logic [11:0] BSG_LINK_CH0_LANES = {3'd5, 3'd4, 3'd1, 3'd0};
  localparam logic [11:0] BSG_LINK_CH1_LANES = {3'd7, 3'd6, 3'd3, 3'd2};

  function automatic logic [2:0] bsg_link_lane(input bsg_link_step_t step, input logic ch);
    return ch ? BSG_LINK_CH1_LANES[3*step +: 3] : BSG_LINK_CH0_LANES[3*step +: 3];
  endfunction

endpackage

// File: rtl/bsg_downstream_in_if.sv
// Link-side beat inputs, credit return and the core-side FWFT word port of the link receiver.
// master = transmitter/core environment, slave = receiver.
interface bsg_downstream_in_if
  import bsg_link_pkg::*;
#(
  parameter int CH_WIDTH = BSG_LINK_CH_WIDTH
);
  localparam int WORD_W = CH_WIDTH * BSG_LINK_STEPS * 2;

  logic                io_valid_in;
  logic [CH_WIDTH-1:0] io_data_in_ch0;
  logic [CH_WIDTH-1:0] io_data_in_ch1;
  logic                io_token_out;
  logic [WORD_W-1:0]   core_data_out;
  logic                core_valid_out;
  logic                core_yumi_in;

  modport master (
    output io_valid_in, io_data_in_ch0, io_data_in_ch1, core_yumi_in,
    input  io_token_out, core_data_out, core_valid_out
  );

  modport slave (
    input  io_valid_in, io_data_in_ch0, io_data_in_ch1, core_yumi_in,
    output io_token_out, core_data_out, core_valid_out
  );
endinterface

// File: rtl/bsg_link_rx_fifo.sv
// First-word fall-through FIFO with occupancy count; enqueue and dequeue may share a cycle, even when full.
// Latency: written word visible at the head one cycle later; writes while full without a dequeue are refused.
module bsg_link_rx_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_vld_i,
  input  logic [WIDTH-1:0] enq_dat_i,
  input  logic             deq_rdy_i,
  output logic [WIDTH-1:0] deq_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr, rd;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign rd = deq_rdy_i & ~empty_o;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign wr = enq_vld_i & (~full_o | rd);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(wr) - CW'(rd);
    if (wr) wptr_d = wptr_q + 1'b1;
    if (rd) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q] <= enq_dat_i;
  end

  assign deq_dat_o = empty_o ? '0 : mem[rptr_q];

endmodule

// File: rtl/bsg_downstream_in.sv
// Link receiver: reassembles 4 two-channel beats into a 64-bit word, buffers it in a credit-sized FWFT FIFO.
// Word visible one cycle after its last beat; one credit token the cycle after each pop; no beat backpressure.
module bsg_downstream_in
  import bsg_link_pkg::*;
#(
  parameter int CH_WIDTH   = BSG_LINK_CH_WIDTH,
  parameter int FIFO_DEPTH = BSG_LINK_CREDITS
) (
  input  logic                clk,
  input  logic                rst,
  bsg_downstream_in_if.slave  bus,
  output logic                overflow_err,
  output bsg_link_step_t      rx_step
);

  localparam int WORD_W = CH_WIDTH * BSG_LINK_STEPS * 2;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  bsg_link_step_t    step_q, step_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] enq_word;
  logic              token_q;
  logic              ovf_q, ovf_d;
  logic              beat_last;
  logic              pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign beat_last = bus.io_valid_in & (step_q == BSG_LINK_LAST_STEP);
  assign pop       = bus.core_yumi_in & ~fifo_empty;

  always_comb begin
    step_d   = step_q;
    asm_d    = asm_q;
    enq_word = asm_q;
    // The last beat's bytes bypass the assembly register straight into the enqueued word.
    enq_word[int'(bsg_link_lane(BSG_LINK_LAST_STEP, 1'b0))*CH_WIDTH +: CH_WIDTH] = bus.io_data_in_ch0;
    enq_word[int'(bsg_link_lane(BSG_LINK_LAST_STEP, 1'b1))*CH_WIDTH +: CH_WIDTH] = bus.io_data_in_ch1;
    if (bus.io_valid_in) begin
      step_d = step_q + 1'b1;
      if (!beat_last) begin
        asm_d[int'(bsg_link_lane(step_q, 1'b0))*CH_WIDTH +: CH_WIDTH] = bus.io_data_in_ch0;
        asm_d[int'(bsg_link_lane(step_q, 1'b1))*CH_WIDTH +: CH_WIDTH] = bus.io_data_in_ch1;
      end
    end
    ovf_d = ovf_q | (beat_last & fifo_full & ~pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q  <= '0;
      asm_q   <= '0;
      token_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      step_q  <= step_d;
      asm_q   <= asm_d;
      token_q <= pop;
      ovf_q   <= ovf_d;
    end
  end

  bsg_link_rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .enq_vld_i (beat_last),
    .enq_dat_i (enq_word),
    .deq_rdy_i (bus.core_yumi_in),
    .deq_dat_o (bus.core_data_out),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign bus.core_valid_out = ~fifo_empty;
  assign bus.io_token_out   = token_q;
  assign overflow_err       = ovf_q;
  assign rx_step            = step_q;

  a_count_bound: assert property (@(posedge clk) disable iff (rst) fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: doc/bsg_downstream_in.md
# bsg_downstream_in

Receive end of the two-channel byte-serial upstream link. Captures 8-bit beats on two channels, reassembles each 64-bit core word from four beats, and buffers words in a 64-entry FIFO toward the core. Returns one credit token to the transmitter per word the core consumes, closing the 64-word outstanding-credit loop the upstream sender enforces.

## Interface
- CH_WIDTH, default 8: width of each link channel.
- FIFO_DEPTH, default 64: words buffered; equals the upstream credit limit.
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- io_valid_in  input  1  link beat valid; one beat per cycle while high.
- io_data_in_ch0  input  8  channel 0 byte.
- io_data_in_ch1  input  8  channel 1 byte.
- io_token_out  output  1  one-cycle credit pulse per consumed word.
- core_data_out  output  64  FIFO head word.
- core_valid_out  output  1  FIFO non-empty.
- core_yumi_in  input  1  core consumes the head word this cycle.
- overflow_err  output  1  sticky: a completed word arrived while the FIFO was full.
- rx_step  output  2  current beat index, for debug and verification.

## Operation
- Word split: cycle0 = word[31:0], cycle1 = word[63:32].
- The beat index `step` is 0..3 and advances by 1 on each `io_valid_in` beat, wrapping 3 -> 0. It holds while `io_valid_in` is low.
- Beat mapping:
  - step 0: ch0 -> cycle0[7:0], ch1 -> cycle0[23:16].
  - step 1: ch0 -> cycle0[15:8], ch1 -> cycle0[31:24].
  - step 2: ch0 -> cycle1[7:0], ch1 -> cycle1[23:16].
  - step 3: ch0 -> cycle1[15:8], ch1 -> cycle1[31:24].
- Steps 0-2 write their bytes into the assembly register. On the step 3 beat, the full 64-bit word (assembly register plus the step 3 bytes) is enqueued.
- FIFO is first-word fall-through: `core_valid_out` = !empty and `core_data_out` = head.
  - `core_yumi_in` pops the head. `core_yumi_in` while `core_valid_out` is low is ignored; it causes no pop and no token.
- Token: each pop drives `io_token_out` high for exactly one cycle, in the cycle after the pop. Back-to-back pops give back-to-back pulses.
- Overflow: an enqueue while the FIFO is full and no pop occurs in the same cycle drops the word and sets `overflow_err`. `overflow_err` clears only on `rst`. The step counter still wraps.
- Occupancy counter is 7 bits (0..64); read and write pointers are 6 bits and wrap modulo 64.

## Timing
- Reset values: `step` = 0; `rx_step` = 0; `core_valid_out` = 0; `core_data_out` = 0; `io_token_out` = 0; `overflow_err` = 0; assembly register = 0; pointers and count = 0.
- Latency: step 3 beat sampled at edge T -> `core_valid_out` = 1 with the word after edge T, with no bypass of an empty FIFO.
- Pop at edge T -> `io_token_out` high for the cycle after T.
- Simultaneous enqueue and pop:
  - FIFO full: both occur, count stays 64, no overflow.
  - FIFO holding 1 word: the old head pops and the new word becomes head, with `core_valid_out` staying 1.
- A gap in `io_valid_in` mid-word holds `step` and the partial word. There is no timeout.
- `rst` asserted mid-word or mid-FIFO: the partial word and all buffered words are discarded and no tokens are issued for them. Upstream must reset concurrently.

## Structure
- Shared package `bsg_link_pkg`:
  - `BSG_LINK_CH_WIDTH` = 8.
  - `BSG_LINK_STEPS` = 4.
  - `BSG_LINK_CREDITS` = 64.
  - 2-bit step typedef.
  - Beat-to-byte-lane mapping constants, also used by the upstream sender.
- Sub-module `bsg_link_rx_fifo`: 64x64 FWFT FIFO with a 7-bit count, full/empty outputs, and same-cycle enqueue/dequeue.
- Top level holds the step counter, assembly register, token flop and overflow flag.

## Test plan
- Single word: beats (ch0, ch1) = (11,33), (22,44), (55,77), (66,88), consecutive, last beat at edge T -> `core_data_out` = 64'h8877665544332211 and `core_valid_out` = 1 after T. `core_yumi_in` at edge T+3 -> `io_token_out` = 1 for exactly one cycle after T+3, `core_valid_out` = 0.
- Gapped beats: `io_valid_in` low for 5 cycles between step 1 and step 2 -> same word assembled, `rx_step` holds at 2 during the gap.
- Fill: 64 words sent, no yumi -> count = 64, `overflow_err` = 0. A 65th word -> dropped, `overflow_err` = 1 and stays 1. Then 64 pops -> 64 token pulses, data matching words 1..64 in order.
- Full with simultaneous pop: FIFO at 64, last beat and yumi at the same edge -> count stays 64, `overflow_err` = 0, new word delivered last.
- Spurious yumi: `core_yumi_in` = 1 with FIFO empty -> no token, no pointer change.
- Reset mid-word: after 2 beats, `rst` pulsed asynchronously -> all outputs 0 immediately. The next 4 beats form a correct word starting at step 0.
